multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath. Decodes the 6-bit opcode latched in the instruction register and steps the shared datapath through fetch, decode, execute, memory and write-back. One ALU and one unified instruction/data memory serve every phase. Memory accesses stall on a ready handshake, and unsupported opcodes park the core in a sticky trap state.

## Interface
- No parameters; opcode and state widths are fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  opcode from instruction register (IR[31:26]), sampled only in DECODE
- MemReady  in  1  memory completes current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  datapath enables/selects
- MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath selects/enables
- ALUSrcB  out  2  00 regB, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- InstrDone  out  1  one-cycle pulse when an instruction retires
- IllegalOp  out  1  sticky; set on unsupported opcode
- State  out  4  current state (debug)

## Operation
- State register is 4 bits. Encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=15.
  - Unused encodings go to IDLE on the next edge.
- Outputs are combinational decodes of State (plus MemReady where noted). Every signal not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by Op:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EX
    - any other value → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD when Op=100011, MEMWR when Op=101011. Op is held stable by the IR.
- MEMRD: MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state is FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next state is FETCH.
- TRAP: all outputs 0. Remains in TRAP until reset. IllegalOp is set on entry to TRAP and cleared only by reset.
- InstrDone=1 in any cycle whose next state is FETCH and whose current state is not IDLE or FETCH:
  - MEMWB, ALUWB, BRANCH, JUMP, ADDI_WB: unconditionally.
  - MEMWR: only when MemReady=1.

## Timing
- Reset: State=IDLE, IllegalOp=0, and every other output is 0 while rst_n=0. Deassertion is synchronized externally.
- First fetch starts on the first rising edge after rst_n rises: IDLE→FETCH.
- Latency with MemReady held high (FETCH through retire):
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - addi: 4 cycles
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-instruction aborts immediately and asynchronously to IDLE. No partial write is issued after rst_n falls.
- MemRead and MemWrite are never asserted in the same cycle. RegWrite is never asserted together with MemRead or MemWrite.

## Test plan
- Reset, then rst_n=1, Op=000000, MemReady=1 → State 0,1,2,7,8,1. RegWrite=1 and RegDst=1 in state 8. InstrDone pulses exactly once.
- lw (Op=100011), MemReady=0 for 3 cycles in FETCH and 2 cycles in MEMRD → FETCH occupies 4 cycles and IRWrite=1 only in the last. MEMRD occupies 3 cycles. MEMWB asserts MemtoReg=1 and RegWrite=1. Total 10 cycles.
- sw (Op=101011) → MEMWR asserts MemWrite=1 and IorD=1. RegWrite stays 0 throughout. InstrDone is coincident with MemReady=1 in MEMWR.
- beq (Op=000100), then j (Op=000010) → BRANCH gives ALUOp=01, PCWriteCond=1, PCSource=01. JUMP gives PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- Op=111111 at DECODE → State=15, IllegalOp=1, all outputs 0 for 20 cycles. Toggling MemReady has no effect. Reset clears IllegalOp to 0.
- Assert rst_n=0 during MEMWR with MemReady=0 → MemWrite drops in the same cycle (asynchronous) and State=0. Recovery starts a fresh FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: steps the shared ALU/memory datapath
// through fetch, decode, execute, memory and write-back; traps on bad opcodes.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       InstrDone,
   output logic       IllegalOp,
   output logic [3:0] State
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDI_EX = 4'd11,
      S_ADDI_WB = 4'd12,
      S_TRAP    = 4'd15
   } state_t;

   state_t state;
   state_t next_state;

   // State register plus the sticky illegal-opcode flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         IllegalOp <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state == S_TRAP) begin
            IllegalOp <= 1'b1;
         end
      end
   end

   // Next-state and datapath control decode of the current state
   always_comb begin
      next_state  = S_IDLE;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;

      case (state)
         S_IDLE: begin
            next_state = S_FETCH;
         end
         S_FETCH: begin
            MemRead    = 1'b1;
            ALUSrcB    = 2'b01;
            IRWrite    = MemReady;
            PCWrite    = MemReady;
            next_state = MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is precomputed while the opcode is decoded
            ALUSrcB = 2'b11;
            case (Op)
               OP_RTYPE:     next_state = S_EXEC;
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_BEQ:       next_state = S_BRANCH;
               OP_J:         next_state = S_JUMP;
               OP_ADDI:      next_state = S_ADDI_EX;
               default:      next_state = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemRead    = 1'b1;
            IorD       = 1'b1;
            next_state = MemReady ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            next_state = MemReady ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            ALUSrcA    = 1'b1;
            ALUOp      = 2'b10;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            next_state  = S_FETCH;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            next_state = S_FETCH;
         end
         S_ADDI_EX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            RegWrite   = 1'b1;
            next_state = S_FETCH;
         end
         S_TRAP: begin
            next_state = S_TRAP;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // An instruction retires whenever a non-fetch state hands back to FETCH
   assign InstrDone = (next_state == S_FETCH) && (state != S_IDLE) && (state != S_FETCH);
   assign State     = 4'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, the
// memory stall handshake, the illegal-opcode trap and asynchronous reset.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] Op;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic       InstrDone, IllegalOp;
   logic [3:0] State;
   logic [16:0] outs;

   int total = 0;
   int bad   = 0;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
      .State(State)
   );

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite}_{MemtoReg,RegDst,RegWrite,ALUSrcA}_
   // {ALUSrcB}_{ALUOp}_{PCSource}_{InstrDone}
   assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone};

   localparam logic [16:0] O_ZERO    = 17'b000000_0000_00_00_00_0;
   localparam logic [16:0] O_FETCH0  = 17'b000100_0000_01_00_00_0;
   localparam logic [16:0] O_FETCH1  = 17'b100101_0000_01_00_00_0;
   localparam logic [16:0] O_DECODE  = 17'b000000_0000_11_00_00_0;
   localparam logic [16:0] O_MEMADR  = 17'b000000_0001_10_00_00_0;
   localparam logic [16:0] O_MEMRD   = 17'b001100_0000_00_00_00_0;
   localparam logic [16:0] O_MEMWB   = 17'b000000_1010_00_00_00_1;
   localparam logic [16:0] O_MEMWR0  = 17'b001010_0000_00_00_00_0;
   localparam logic [16:0] O_MEMWR1  = 17'b001010_0000_00_00_00_1;
   localparam logic [16:0] O_EXEC    = 17'b000000_0001_00_10_00_0;
   localparam logic [16:0] O_ALUWB   = 17'b000000_0110_00_00_00_1;
   localparam logic [16:0] O_BRANCH  = 17'b010000_0001_00_01_01_1;
   localparam logic [16:0] O_JUMP    = 17'b100000_0000_00_00_10_1;
   localparam logic [16:0] O_ADDIWB  = 17'b000000_0010_00_00_00_1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // State, full control vector and trap flag at one sample point
   task automatic chk(input string tag, input logic [3:0] st, input logic [16:0] o, input logic ill);
      check({tag, ".state"}, 17'(State), 17'(st));
      check({tag, ".outs"}, outs, o);
      check({tag, ".illegal"}, 17'(IllegalOp), 17'(ill));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; Op = 6'b000000; MemReady = 1'b0;
      #1;
      chk("reset", 4'd0, O_ZERO, 1'b0);
      step(); step();
      rst_n = 1'b1; MemReady = 1'b1; #1;
      chk("idle", 4'd0, O_ZERO, 1'b0);

      // R-type
      step(); chk("r.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("r.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("r.exec",   4'd7, O_EXEC,   1'b0);
      step(); chk("r.aluwb",  4'd8, O_ALUWB,  1'b0);

      // lw with 3 fetch stalls and 2 memory stalls
      step(); Op = 6'b100011; MemReady = 1'b0; #1;
      chk("lw.fetch1", 4'd1, O_FETCH0, 1'b0);
      step(); chk("lw.fetch2", 4'd1, O_FETCH0, 1'b0);
      step(); chk("lw.fetch3", 4'd1, O_FETCH0, 1'b0);
      step(); MemReady = 1'b1; #1;
      chk("lw.fetch4", 4'd1, O_FETCH1, 1'b0);
      step(); chk("lw.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("lw.memadr", 4'd3, O_MEMADR, 1'b0);
      step(); MemReady = 1'b0; #1;
      chk("lw.memrd1", 4'd4, O_MEMRD, 1'b0);
      step(); chk("lw.memrd2", 4'd4, O_MEMRD, 1'b0);
      step(); MemReady = 1'b1; #1;
      chk("lw.memrd3", 4'd4, O_MEMRD, 1'b0);
      step(); chk("lw.memwb", 4'd5, O_MEMWB, 1'b0);

      // sw with one write stall
      step(); Op = 6'b101011; #1;
      chk("sw.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("sw.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("sw.memadr", 4'd3, O_MEMADR, 1'b0);
      step(); MemReady = 1'b0; #1;
      chk("sw.memwr0", 4'd6, O_MEMWR0, 1'b0);
      step(); MemReady = 1'b1; #1;
      chk("sw.memwr1", 4'd6, O_MEMWR1, 1'b0);

      // beq then j
      step(); Op = 6'b000100; #1;
      chk("beq.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("beq.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("beq.branch", 4'd9, O_BRANCH, 1'b0);
      step(); Op = 6'b000010; #1;
      chk("j.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("j.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("j.jump",   4'd10, O_JUMP,  1'b0);

      // addi
      step(); Op = 6'b001000; #1;
      chk("addi.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("addi.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("addi.ex",     4'd11, O_MEMADR, 1'b0);
      step(); chk("addi.wb",     4'd12, O_ADDIWB, 1'b0);

      // Illegal opcode parks in TRAP regardless of MemReady / Op
      step(); Op = 6'b111111; #1;
      chk("trap.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("trap.decode", 4'd2, O_DECODE, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("trap.hold", 4'd15, O_ZERO, 1'b1);
         MemReady = ~MemReady;
         Op = 6'(i);
      end
      rst_n = 1'b0; #1;
      chk("trap.reset", 4'd0, O_ZERO, 1'b0);
      step();
      rst_n = 1'b1; MemReady = 1'b1; Op = 6'b101011; #1;

      // Asynchronous reset while a store is stalled
      step(); chk("ar.fetch",  4'd1, O_FETCH1, 1'b0);
      step(); chk("ar.decode", 4'd2, O_DECODE, 1'b0);
      step(); chk("ar.memadr", 4'd3, O_MEMADR, 1'b0);
      step(); MemReady = 1'b0; #1;
      chk("ar.memwr", 4'd6, O_MEMWR0, 1'b0);
      #1 rst_n = 1'b0; #1;
      chk("ar.abort", 4'd0, O_ZERO, 1'b0);
      step(); chk("ar.held", 4'd0, O_ZERO, 1'b0);
      rst_n = 1'b1; MemReady = 1'b1; #1;
      step(); chk("ar.refetch", 4'd1, O_FETCH1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
